// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: LFSR test-pattern source for a combinational CUT.
//
// After a start pulse the block emits num_patterns pseudo-random vectors over
// a valid/ready handshake and then raises a sticky done flag.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          single-cycle run request (ignored while busy)
//   seed           initial LFSR state, sampled on an accepted start
//   num_patterns   number of patterns to emit, sampled on an accepted start
//   pattern_ready  downstream accepts the current pattern
//   pattern        current vector (pattern[0..4] = N1,N2,N3,N6,N7 of c17)
//   pattern_valid  pattern holds a valid vector
//   pattern_index  0-based index of the current pattern
//   busy           high while patterns are being emitted
//   done           high after the last pattern, until the next start
//
// Build option:
//   BIST_PATTERN_GEN_EXHAUSTIVE_EN  de Bruijn mode. The all-zero state is
//                                   spliced into the sequence, so all 2^WIDTH
//                                   vectors appear and a zero seed is legal.
module bist_pattern_gen #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic             pattern_ready,
  output logic [WIDTH-1:0] pattern,
  output logic             pattern_valid,
  output logic [CNT_W-1:0] pattern_index,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] VEC_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] VEC_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // One step of the Fibonacci LFSR; in de Bruijn mode the feedback is
  // inverted when the low bits are all zero, which splices 0 after 10..0.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic fb;
    fb = ^(s & TAPS);
`ifdef BIST_PATTERN_GEN_EXHAUSTIVE_EN
    fb = fb ^ (s[WIDTH-2:0] == {(WIDTH-1){1'b0}});
`endif
    return {s[WIDTH-2:0], fb};
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] lfsr_r;
  logic [WIDTH-1:0] lfsr_next_s;
  logic [CNT_W-1:0] index_next_s;
  logic [CNT_W-1:0] target_r;
  logic [CNT_W-1:0] target_next_s;
  logic [WIDTH-1:0] seed_fixed_s;
  logic             transfer_s;

  // Seed conditioning: a plain LFSR must never be loaded with zero.
  always_comb begin
`ifdef BIST_PATTERN_GEN_EXHAUSTIVE_EN
    seed_fixed_s = seed;
`else
    if (seed == VEC_ZERO) begin
      seed_fixed_s = VEC_ONE;
    end else begin
      seed_fixed_s = seed;
    end
`endif
  end

  assign transfer_s = pattern_valid & pattern_ready;

  // Next-state, next-LFSR and next-index logic.
  always_comb begin
    state_next_s  = state_r;
    lfsr_next_s   = lfsr_r;
    index_next_s  = pattern_index;
    target_next_s = target_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          lfsr_next_s   = seed_fixed_s;
          index_next_s  = CNT_ZERO;
          target_next_s = num_patterns;
          if (num_patterns == CNT_ZERO) begin
            state_next_s = DONE;
          end else begin
            state_next_s = RUN;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      RUN: begin
        if (transfer_s) begin
          if (pattern_index == (target_r - CNT_ONE)) begin
            state_next_s = DONE;
          end else begin
            lfsr_next_s  = lfsr_step(lfsr_r);
            index_next_s = pattern_index + CNT_ONE;
          end
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs. Outputs are decoded from the
  // next state so they line up with the state register without extra delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      lfsr_r        <= VEC_ZERO;
      target_r      <= CNT_ZERO;
      pattern       <= VEC_ZERO;
      pattern_index <= CNT_ZERO;
      pattern_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      lfsr_r        <= lfsr_next_s;
      target_r      <= target_next_s;
      pattern_index <= index_next_s;
      pattern_valid <= (state_next_s == RUN);
      busy          <= (state_next_s == RUN);
      done          <= (state_next_s == DONE);
      // pattern follows the LFSR only while emitting; it holds in DONE.
      if (state_next_s == RUN) begin
        pattern <= lfsr_next_s;
      end else begin
        pattern <= pattern;
      end
    end
  end

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Self-checking bench for bist_pattern_gen (default parameters).
// The reference model steps a 5-bit Fibonacci sequence with taps on bits 4
// and 2 using plain integer arithmetic; in de Bruijn builds it splices 0
// between 16 and 1.
module tb_bist_pattern_gen;

`ifdef BIST_PATTERN_GEN_EXHAUSTIVE_EN
  localparam bit EXH = 1'b1;
`else
  localparam bit EXH = 1'b0;
`endif
  localparam int W     = 5;
  localparam int TAPSI = 20; // 5'b10100

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] seed = 5'd0;
  logic [7:0] num_patterns = 8'd0;
  logic       pattern_ready = 1'b0;
  logic [4:0] pattern;
  logic       pattern_valid;
  logic [7:0] pattern_index;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int seen_cnt [32];

  bist_pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .num_patterns(num_patterns), .pattern_ready(pattern_ready),
    .pattern(pattern), .pattern_valid(pattern_valid),
    .pattern_index(pattern_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int model_next(input int s);
    int fb;
    fb = 0;
    for (int i = 0; i < W; i++) begin
      if (((TAPSI >> i) & 1) == 1) fb = fb ^ ((s >> i) & 1);
    end
    if (EXH && s == 16) return 0;
    if (EXH && s == 0) return 1;
    return ((s * 2) % 32) + fb;
  endfunction

  // Runs one start..done transaction and checks every observed cycle.
  task automatic run_seq(input logic [4:0] sd, input int n, input int ready_pct,
                         input int stall_idx, input int stall_len, input bit poke_start);
    int exp_q[$];
    int s, got, stall_left, cycles;
    logic [4:0] e;
    logic [4:0] last;
    for (int v = 0; v < 32; v++) seen_cnt[v] = 0;
    s = (sd == 5'd0 && !EXH) ? 1 : int'(sd);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(s);
      s = model_next(s);
    end
    @(negedge clk);
    start = 1'b1; seed = sd; num_patterns = n[7:0]; pattern_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || pattern_valid !== 1'b1 || pattern_index !== 8'd0) begin
      n_fail++;
      $display("FAIL start_response: done=%b valid=%b index=%0d required done=0 valid=1 index=0",
               done, pattern_valid, pattern_index);
    end
    got = 0; stall_left = stall_len; cycles = 0;
    while (got < n && cycles < n * 20 + 50) begin
      e = exp_q[got][4:0];
      n_checks++;
      if (pattern_valid !== 1'b1 || busy !== 1'b1 || pattern !== e || pattern_index !== got[7:0]) begin
        n_fail++;
        $display("FAIL run_cycle: valid=%b busy=%b pattern=%b index=%0d required valid=1 busy=1 pattern=%b index=%0d",
                 pattern_valid, busy, pattern, pattern_index, e, got);
      end
      if (got == stall_idx && stall_left > 0) begin
        pattern_ready = 1'b0;
        stall_left--;
      end else begin
        pattern_ready = ($urandom_range(0, 99) < ready_pct);
      end
      if (poke_start && got == 2) begin
        start = 1'b1; seed = ~sd; num_patterns = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (pattern_ready) begin
        seen_cnt[e]++;
        got++;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    pattern_ready = 1'b0;
    n_checks++;
    if (got < n) begin
      n_fail++;
      $display("FAIL run_timeout: transfers=%0d required %0d", got, n);
    end
    last = exp_q[n-1][4:0];
    n_checks++;
    if (pattern_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || pattern !== last) begin
      n_fail++;
      $display("FAIL end_state: valid=%b done=%b busy=%b pattern=%b required valid=0 done=1 busy=0 pattern=%b",
               pattern_valid, done, busy, pattern, last);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    n_checks++;
    if (pattern !== 5'd0 || pattern_index !== 8'd0 || pattern_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: pattern=%b index=%0d valid=%b busy=%b done=%b required all zero",
               name, pattern, pattern_index, pattern_valid, busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_state");
    @(negedge clk);
    start = 1'b1; seed = 5'd9; num_patterns = 8'd4; // start during reset
    @(negedge clk);
    check_zero_outputs("reset_beats_start");
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("idle_after_reset");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1; seed = 5'b00001; num_patterns = 8'd10;
    @(negedge clk);
    start = 1'b0; pattern_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pattern_valid !== 1'b1 || pattern_index !== 8'd3) begin
      n_fail++;
      $display("FAIL pre_reset_run: valid=%b index=%0d required valid=1 index=3", pattern_valid, pattern_index);
    end
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_reset_mid_run");
    pattern_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("idle_after_mid_reset");
  endtask

  task automatic test_nominal();
    run_seq(5'b00001, 6, 100, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_seq(5'b00001, 6, 100, 2, 4, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      run_seq(5'($urandom_range(1, 31)), int'($urandom_range(1, 40)), 60, -1, 0, 1'b0);
    end
  endtask

  task automatic test_zero_count();
    @(negedge clk);
    start = 1'b1; seed = 5'($urandom_range(0, 31)); num_patterns = 8'd0;
    @(negedge clk);
    start = 1'b0; pattern_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (done !== 1'b1 || pattern_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_count: cycle=%0d done=%b valid=%b busy=%b required done=1 valid=0 busy=0",
                 k, done, pattern_valid, busy);
      end
      @(negedge clk);
    end
    pattern_ready = 1'b0;
  endtask

  task automatic test_zero_seed();
    run_seq(5'd0, 4, 100, -1, 0, 1'b0);
  endtask

  task automatic test_start_in_run();
    run_seq(5'b01101, 10, 70, -1, 0, 1'b1);
  endtask

  task automatic test_full_period();
    int req;
    run_seq(5'b00001, EXH ? 32 : 31, 100, -1, 0, 1'b0);
    for (int v = 0; v < 32; v++) begin
      req = (v == 0 && !EXH) ? 0 : 1;
      n_checks++;
      if (seen_cnt[v] != req) begin
        n_fail++;
        $display("FAIL full_period: vector=%0d seen=%0d required %0d", v, seen_cnt[v], req);
      end
    end
  endtask

  task automatic test_restart();
    run_seq(5'b00011, 4, 100, -1, 0, 1'b0);
    run_seq(5'b10110, 5, 80, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_nominal();
    test_backpressure();
    test_zero_count();
    test_zero_seed();
    test_start_in_run();
    test_full_period();
    test_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
